// File: rtl/elgamal_encrypt_session_if.sv
// Stream bundle for elgamal_encrypt_session: configuration beat, plaintext stream,
// ciphertext stream and status. The encryptor uses the slave modport.
interface elgamal_encrypt_session_if #(
  parameter int SIZE = 64
);
  logic [SIZE-1:0] cfg_p_tdata;
  logic [SIZE-1:0] cfg_alpha_tdata;
  logic [SIZE-1:0] cfg_beta_tdata;
  logic [SIZE-1:0] cfg_seed_tdata;
  logic            cfg_tvalid;
  logic            cfg_tready;
  logic            cfg_err;
  logic [SIZE-1:0] msg_tdata;
  logic            msg_tlast;
  logic            msg_tvalid;
  logic            msg_tready;
  logic [SIZE-1:0] out_c1_tdata;
  logic [SIZE-1:0] out_c2_tdata;
  logic            out_tuser;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready;
  logic            busy;

  modport master (
    output cfg_p_tdata, cfg_alpha_tdata, cfg_beta_tdata, cfg_seed_tdata, cfg_tvalid,
    output msg_tdata, msg_tlast, msg_tvalid, out_tready,
    input  cfg_tready, cfg_err, msg_tready,
    input  out_c1_tdata, out_c2_tdata, out_tuser, out_tlast, out_tvalid, busy
  );

  modport slave (
    input  cfg_p_tdata, cfg_alpha_tdata, cfg_beta_tdata, cfg_seed_tdata, cfg_tvalid,
    input  msg_tdata, msg_tlast, msg_tvalid, out_tready,
    output cfg_tready, cfg_err, msg_tready,
    output out_c1_tdata, out_c2_tdata, out_tuser, out_tlast, out_tvalid, busy
  );
endinterface

// File: rtl/elgamal_encrypt_session.sv
// Session-based ElGamal encryptor: one config beat, then a stream of messages each
// turned into (alpha^k, m*beta^k) mod p with constant-time square-and-multiply.
module elgamal_encrypt_session #(
  parameter int          SIZE      = 64,
  parameter int          KEY_MODE  = 0,
  parameter logic [63:0] LFSR_TAPS = 64'hD800000000000000
) (
  input logic clk,
  input logic rst,
  elgamal_encrypt_session_if.slave io
);

  localparam int              CW      = $clog2(SIZE);
  localparam logic [CW-1:0]   LAST    = CW'(SIZE - 1);
  localparam logic [SIZE-1:0] ONE     = SIZE'(1);
  localparam logic [SIZE-1:0] TWO     = SIZE'(2);
  localparam logic [SIZE-1:0] THREE   = SIZE'(3);
  localparam logic [SIZE-1:0] TAPS    = SIZE'(LFSR_TAPS);
  localparam bit              FIXED_K = (KEY_MODE != 0);

  typedef enum logic [2:0] {IDLE, READY, KEYGEN, EXP, MUL, OUT} state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0] p_q, alpha_q, beta_q, lfsr_q, k_q, m_q;
  logic [SIZE-1:0] x1_q, x2_q, a1_q, a2_q, b1_q, b2_q, r1_q, r2_q;
  logic [SIZE-1:0] c1_q, c2_q;
  logic            tlast_q, tuser_q, cfg_err_q, phase_q;
  logic [CW-1:0]   cyc_q, bit_q;

  // One interleaved shift-add step: r = 2r + bit*a, reduced twice into [0, p).
  function automatic logic [SIZE-1:0] mm_step(input logic [SIZE-1:0] r,
                                              input logic [SIZE-1:0] a,
                                              input logic [SIZE-1:0] p,
                                              input logic            b);
    logic [SIZE:0] t;
    t = {r, 1'b0};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    if (b) t = t + {1'b0, a};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    return t[SIZE-1:0];
  endfunction

  function automatic logic [SIZE-1:0] lfsr_step(input logic [SIZE-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  logic            cfg_fire, cfg_ok, msg_fire, m_bad, k_ok, last_cyc, last_bit;
  logic [SIZE-1:0] lfsr_nx, r1_nx, r2_nx, sel1, sel2;

  assign cfg_fire = io.cfg_tvalid && (state_q == IDLE);
  assign cfg_ok   = (io.cfg_p_tdata >= THREE) && (io.cfg_alpha_tdata < io.cfg_p_tdata) &&
                    (io.cfg_beta_tdata < io.cfg_p_tdata);
  assign msg_fire = io.msg_tvalid && (state_q == READY);
  assign m_bad    = (io.msg_tdata >= p_q);
  assign lfsr_nx  = lfsr_step(lfsr_q);
  assign k_ok     = (lfsr_nx != '0) && (lfsr_nx <= p_q - TWO);
  assign last_cyc = (cyc_q == LAST);
  assign last_bit = (bit_q == LAST);
  assign r1_nx    = mm_step(r1_q, a1_q, p_q, b1_q[SIZE-1]);
  assign r2_nx    = mm_step(r2_q, a2_q, p_q, b2_q[SIZE-1]);
  // Both products are always computed; the key bit only picks which result survives.
  assign sel1     = k_q[SIZE-1] ? r1_nx : x1_q;
  assign sel2     = k_q[SIZE-1] ? r2_nx : x2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_fire && cfg_ok) state_d = READY;
      READY:   if (msg_fire) state_d = m_bad ? OUT : KEYGEN;
      KEYGEN:  if (FIXED_K || k_ok) state_d = EXP;
      EXP:     if (last_cyc && phase_q && last_bit) state_d = MUL;
      MUL:     if (last_cyc) state_d = OUT;
      OUT:     if (io.out_tready) state_d = tlast_q ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0; alpha_q <= '0; beta_q <= '0; lfsr_q <= '0; k_q <= '0; m_q <= '0;
      x1_q <= '0; x2_q <= '0; a1_q <= '0; a2_q <= '0; b1_q <= '0; b2_q <= '0;
      r1_q <= '0; r2_q <= '0; c1_q <= '0; c2_q <= '0;
      tlast_q <= 1'b0; tuser_q <= 1'b0; cfg_err_q <= 1'b0; phase_q <= 1'b0;
      cyc_q <= '0; bit_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_fire) begin
            if (cfg_ok) begin
              p_q       <= io.cfg_p_tdata;
              alpha_q   <= io.cfg_alpha_tdata;
              beta_q    <= io.cfg_beta_tdata;
              lfsr_q    <= (!FIXED_K && io.cfg_seed_tdata == '0) ? ONE : io.cfg_seed_tdata;
              cfg_err_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (msg_fire) begin
            m_q     <= io.msg_tdata;
            tlast_q <= io.msg_tlast;
            tuser_q <= m_bad;
            c1_q    <= '0;
            c2_q    <= '0;
          end
        end
        KEYGEN: begin
          // In fixed-key mode lfsr_q simply holds k and never steps.
          if (!FIXED_K) lfsr_q <= lfsr_nx;
          k_q     <= FIXED_K ? lfsr_q : lfsr_nx;
          x1_q    <= ONE;  x2_q <= ONE;
          a1_q    <= ONE;  b1_q <= ONE;
          a2_q    <= ONE;  b2_q <= ONE;
          r1_q    <= '0;   r2_q <= '0;
          cyc_q   <= '0;   bit_q <= '0;
          phase_q <= 1'b0;
        end
        EXP: begin
          r1_q  <= r1_nx;
          r2_q  <= r2_nx;
          b1_q  <= b1_q << 1;
          b2_q  <= b2_q << 1;
          cyc_q <= cyc_q + 1'b1;
          if (last_cyc) begin
            cyc_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            if (!phase_q) begin
              x1_q    <= r1_nx;    x2_q <= r2_nx;
              a1_q    <= alpha_q;  a2_q <= beta_q;
              b1_q    <= r1_nx;    b2_q <= r2_nx;
              phase_q <= 1'b1;
            end else begin
              x1_q    <= sel1;     x2_q <= sel2;
              k_q     <= k_q << 1;
              phase_q <= 1'b0;
              if (last_bit) begin
                bit_q <= '0;
                c1_q  <= sel1;
                a2_q  <= m_q;
                b2_q  <= sel2;
              end else begin
                bit_q <= bit_q + 1'b1;
                a1_q  <= sel1;  b1_q <= sel1;
                a2_q  <= sel2;  b2_q <= sel2;
              end
            end
          end
        end
        MUL: begin
          r2_q  <= r2_nx;
          b2_q  <= b2_q << 1;
          cyc_q <= cyc_q + 1'b1;
          if (last_cyc) begin
            cyc_q <= '0;
            c2_q  <= r2_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.cfg_tready   = (state_q == IDLE);
  assign io.msg_tready   = (state_q == READY);
  assign io.out_tvalid   = (state_q == OUT);
  assign io.busy         = (state_q != IDLE) && (state_q != READY);
  assign io.cfg_err      = cfg_err_q;
  assign io.out_c1_tdata = c1_q;
  assign io.out_c2_tdata = c2_q;
  assign io.out_tuser    = tuser_q;
  assign io.out_tlast    = tlast_q;

endmodule

// File: tb/tb_elgamal_encrypt_session.sv
// Bench for elgamal_encrypt_session: a fixed-key instance and an LFSR-key instance,
// both SIZE=8, checked against modular-arithmetic reference computations.
module tb_elgamal_encrypt_session;
  logic clk, rst;
  int total = 0, bad = 0;

  elgamal_encrypt_session_if #(.SIZE(8)) bus1 ();
  elgamal_encrypt_session_if #(.SIZE(8)) bus0 ();

  elgamal_encrypt_session #(.SIZE(8), .KEY_MODE(1), .LFSR_TAPS(64'hB8)) dut1 (
    .clk(clk), .rst(rst), .io(bus1));
  elgamal_encrypt_session #(.SIZE(8), .KEY_MODE(0), .LFSR_TAPS(64'hB8)) dut0 (
    .clk(clk), .rst(rst), .io(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       use0, cfg_v, m_valid, m_last, o_ready;
  logic [7:0] cfg_p, cfg_a, cfg_b, cfg_s, m_data;

  assign bus1.cfg_p_tdata = cfg_p;     assign bus0.cfg_p_tdata = cfg_p;
  assign bus1.cfg_alpha_tdata = cfg_a; assign bus0.cfg_alpha_tdata = cfg_a;
  assign bus1.cfg_beta_tdata = cfg_b;  assign bus0.cfg_beta_tdata = cfg_b;
  assign bus1.cfg_seed_tdata = cfg_s;  assign bus0.cfg_seed_tdata = cfg_s;
  assign bus1.cfg_tvalid = cfg_v & ~use0;
  assign bus0.cfg_tvalid = cfg_v & use0;
  assign bus1.msg_tdata = m_data;      assign bus0.msg_tdata = m_data;
  assign bus1.msg_tlast = m_last;      assign bus0.msg_tlast = m_last;
  assign bus1.msg_tvalid = m_valid & ~use0;
  assign bus0.msg_tvalid = m_valid & use0;
  assign bus1.out_tready = o_ready;    assign bus0.out_tready = o_ready;

  logic       v_cfg_tready, v_cfg_err, v_msg_tready, v_valid, v_user, v_last, v_busy;
  logic [7:0] v_c1, v_c2;
  assign v_cfg_tready = use0 ? bus0.cfg_tready   : bus1.cfg_tready;
  assign v_cfg_err    = use0 ? bus0.cfg_err      : bus1.cfg_err;
  assign v_msg_tready = use0 ? bus0.msg_tready   : bus1.msg_tready;
  assign v_valid      = use0 ? bus0.out_tvalid   : bus1.out_tvalid;
  assign v_user       = use0 ? bus0.out_tuser    : bus1.out_tuser;
  assign v_last       = use0 ? bus0.out_tlast    : bus1.out_tlast;
  assign v_busy       = use0 ? bus0.busy         : bus1.busy;
  assign v_c1         = use0 ? bus0.out_c1_tdata : bus1.out_c1_tdata;
  assign v_c2         = use0 ? bus0.out_c2_tdata : bus1.out_c2_tdata;

  int   got_c1, got_c2, got_lat;
  logic got_user, got_last, leak;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int modexp(input int b, input int e, input int p);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % p;
    return int'(r);
  endfunction

  function automatic int lfsr8(input int s);
    return (s & 1) ? ((s >> 1) ^ 'hB8) : (s >> 1);
  endfunction

  task automatic do_cfg(input int p, input int a, input int b, input int s);
    int n = 0;
    cfg_p = 8'(p); cfg_a = 8'(a); cfg_b = 8'(b); cfg_s = 8'(s); cfg_v = 1'b1;
    while (!v_cfg_tready && n < 3000) begin tick(); n++; end
    chk("cfg_ready_wait", v_cfg_tready, 1);
    tick();
    cfg_v = 1'b0;
  endtask

  task automatic do_msg(input int m, input bit tl, input int hold);
    int  n = 0;
    logic unstable = 1'b0;
    m_data = 8'(m); m_last = tl; m_valid = 1'b1;
    while (!v_msg_tready && n < 3000) begin tick(); n++; end
    chk("msg_ready_wait", v_msg_tready, 1);
    tick();
    m_valid = 1'b0;
    got_lat = 1;
    leak = 1'b0;
    while (!v_valid && got_lat < 3000) begin
      if (v_msg_tready) leak = 1'b1;
      tick();
      got_lat++;
    end
    got_c1 = v_c1; got_c2 = v_c2; got_user = v_user; got_last = v_last;
    if (hold > 0) begin
      o_ready = 1'b0;
      m_data = 8'(m + 1); m_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!v_valid || v_c1 != 8'(got_c1) || v_c2 != 8'(got_c2) || v_user != got_user ||
            v_last != got_last) unstable = 1'b1;
        if (v_msg_tready) leak = 1'b1;
      end
      chk("hold_stable", unstable, 0);
      o_ready = 1'b1;
    end
    tick();
    m_valid = 1'b0;
    chk("tvalid_after_xfer", v_valid, 0);
  endtask

  initial begin
    int ec1, ec2, x, beta0, s, r, k, m, cnt;
    bit tl, rej;
    rst = 1'b1; use0 = 1'b0; cfg_v = 1'b0; m_valid = 1'b0; m_last = 1'b0; o_ready = 1'b1;
    cfg_p = '0; cfg_a = '0; cfg_b = '0; cfg_s = '0; m_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_tready", v_cfg_tready, 1);
    chk("rst_cfg_err", v_cfg_err, 0);
    chk("rst_msg_tready", v_msg_tready, 0);
    chk("rst_out_tvalid", v_valid, 0);
    chk("rst_busy", v_busy, 0);
    chk("rst_c1", v_c1, 0);
    rst = 1'b0;
    tick();

    // Known-answer: p=23 alpha=5 beta=8 k=3, m=7
    do_cfg(23, 5, 8, 3);
    chk("kat_msg_tready", v_msg_tready, 1);
    do_msg(7, 1'b1, 0);
    chk("kat_c1", got_c1, 10);
    chk("kat_c2", got_c2, 19);
    chk("kat_tuser", got_user, 0);
    chk("kat_tlast", got_last, 1);
    chk("kat_latency", got_lat, 138);
    chk("kat_idle", v_cfg_tready, 1);

    // Message stream under one session
    do_cfg(23, 5, 8, 3);
    for (int i = 0; i < 3; i++) begin
      m = (i == 0) ? 1 : (i == 1) ? 22 : 0;
      do_msg(m, i == 2, 0);
      chk("stream_c1", got_c1, modexp(5, 3, 23));
      chk("stream_c2", got_c2, (m * modexp(8, 3, 23)) % 23);
      chk("stream_tlast", got_last, i == 2);
      chk("stream_no_accept_busy", leak, 0);
    end

    // Message rejection keeps the session open
    do_cfg(23, 5, 8, 3);
    do_msg(23, 1'b0, 0);
    chk("rej_tuser", got_user, 1);
    chk("rej_c1", got_c1, 0);
    chk("rej_c2", got_c2, 0);
    chk("rej_latency", got_lat, 1);
    chk("rej_session_open", v_msg_tready, 1);
    m = $urandom_range(0, 22);
    do_msg(m, 1'b1, 0);
    chk("post_rej_c2", got_c2, (m * modexp(8, 3, 23)) % 23);
    chk("post_rej_tuser", got_user, 0);

    // Configuration rejection
    do_cfg(2, 1, 1, 3);
    chk("cfg_p_small_err", v_cfg_err, 1);
    chk("cfg_p_small_idle", v_cfg_tready, 1);
    do_cfg(23, 23, 8, 3);
    chk("cfg_alpha_err", v_cfg_err, 1);
    chk("cfg_alpha_idle", v_cfg_tready, 1);
    do_cfg(23, 5, 30, 3);
    chk("cfg_beta_err", v_cfg_err, 1);
    do_cfg(23, 5, 8, 3);
    chk("cfg_ok_clears_err", v_cfg_err, 0);
    chk("cfg_ok_ready", v_msg_tready, 1);

    // Output backpressure
    m = $urandom_range(1, 22);
    do_msg(m, 1'b0, 50);
    chk("bp_c1", got_c1, 10);
    chk("bp_c2", got_c2, (m * 6) % 23);
    chk("bp_no_accept", leak, 0);
    chk("bp_back_ready", v_msg_tready, 1);
    do_msg(5, 1'b1, 0);
    chk("bp_last_c2", got_c2, (5 * 6) % 23);

    // LFSR keys: 100 messages, decrypted with the private key
    use0 = 1'b1;
    x = $urandom_range(1, 249);
    beta0 = modexp(6, x, 251);
    do_cfg(251, 6, beta0, 0);
    s = 1;
    for (int i = 0; i < 100; i++) begin
      m = $urandom_range(0, 255);
      tl = (i == 99);
      rej = (m >= 251);
      r = 0;
      k = 0;
      if (!rej) begin
        do begin s = lfsr8(s); r++; end while (s < 1 || s > 249);
        k = s;
      end
      do_msg(m, tl, 0);
      chk("lfsr_tlast", got_last, tl);
      chk("lfsr_tuser", got_user, rej);
      if (rej) begin
        chk("lfsr_rej_latency", got_lat, 1);
        chk("lfsr_rej_c1", got_c1, 0);
      end else begin
        ec1 = modexp(6, k, 251);
        ec2 = (m * modexp(beta0, k, 251)) % 251;
        chk("lfsr_c1", got_c1, ec1);
        chk("lfsr_c2", got_c2, ec2);
        chk("lfsr_decrypt", (longint'(got_c2) * modexp(got_c1, 250 - x, 251)) % 251, m);
        chk("lfsr_latency", got_lat, 137 + r);
      end
    end
    chk("lfsr_session_end", v_cfg_tready, 1);

    // Reset during exponentiation
    use0 = 1'b0;
    do_cfg(23, 5, 8, 3);
    m_data = 8'd4; m_last = 1'b1; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    repeat (40) tick();
    chk("abort_busy_before", v_busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_tvalid", v_valid, 0);
    chk("abort_busy", v_busy, 0);
    chk("abort_msg_tready", v_msg_tready, 0);
    chk("abort_c1", v_c1, 0);
    chk("abort_c2", v_c2, 0);
    chk("abort_tlast", v_last, 0);
    tick();
    chk("abort_cfg_tready", v_cfg_tready, 1);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (v_valid) cnt++;
    end
    chk("abort_no_pulse", cnt, 0);
    chk("abort_still_idle", v_cfg_tready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
